// File: rtl/traffic_control.sv
// Four-way round-robin signal controller (N->S->E->W) with demand skipping.
// Optional all-red clearance phase enabled by defining TRAFFIC_CONTROL_ALL_RED_EN.
module traffic_control #(
    parameter int GREEN_TIME  = 8,
    parameter int YELLOW_TIME = 3,
    parameter int ALLRED_TIME = 1
) (
    input  logic       clk,
    input  logic       rst_a,
    input  logic       x1,
    input  logic       x2,
    input  logic       x3,
    input  logic       x4,
    output logic [2:0] n_lights,
    output logic [2:0] s_lights,
    output logic [2:0] e_lights,
    output logic [2:0] w_lights
);

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;

    localparam logic [7:0] GREEN_LAST  = 8'(GREEN_TIME - 1);
    localparam logic [7:0] YELLOW_LAST = 8'(YELLOW_TIME - 1);

    // Approach indices: 0 = North, 1 = South, 2 = East, 3 = West.
    localparam logic [1:0] DIR_N = 2'd0;
    localparam logic [1:0] DIR_S = 2'd1;
    localparam logic [1:0] DIR_E = 2'd2;
    localparam logic [1:0] DIR_W = 2'd3;

    generate
        if (GREEN_TIME < 1 || GREEN_TIME > 255) begin : g_bad_green
            $error("traffic_control: GREEN_TIME out of range 1..255");
        end
        if (YELLOW_TIME < 1 || YELLOW_TIME > 255) begin : g_bad_yellow
            $error("traffic_control: YELLOW_TIME out of range 1..255");
        end
        if (ALLRED_TIME < 1 || ALLRED_TIME > 255) begin : g_bad_allred
            $error("traffic_control: ALLRED_TIME out of range 1..255");
        end
    endgenerate

`ifdef TRAFFIC_CONTROL_ALL_RED_EN
    localparam logic [7:0] ALLRED_LAST = 8'(ALLRED_TIME - 1);

    typedef enum logic [3:0] {
        NG = 4'd0, NY = 4'd1, SG = 4'd2, SY = 4'd3,
        EG = 4'd4, EY = 4'd5, WG = 4'd6, WY = 4'd7,
        AR = 4'd8
    } state_e;
`else
    typedef enum logic [2:0] {
        NG = 3'd0, NY = 3'd1, SG = 3'd2, SY = 3'd3,
        EG = 3'd4, EY = 3'd5, WG = 3'd6, WY = 3'd7
    } state_e;
`endif

    // Observable FSM status: current state plus phase counter.
    typedef struct packed {
        state_e     state;
        logic [7:0] cnt;
    } fsm_t;

    fsm_t fsm_q, fsm_d;

    logic [3:0] sens;
    logic [1:0] cur_dir;
    logic [1:0] sel_dir;

    assign sens = {x4, x3, x2, x1};

    function automatic logic [1:0] dir_of(input state_e s);
        logic [1:0] d;
        case (s)
            NG, NY:  d = DIR_N;
            SG, SY:  d = DIR_S;
            EG, EY:  d = DIR_E;
            WG, WY:  d = DIR_W;
            default: d = DIR_N;
        endcase
        return d;
    endfunction

    function automatic state_e green_of(input logic [1:0] d);
        state_e s;
        case (d)
            DIR_N:   s = NG;
            DIR_S:   s = SG;
            DIR_E:   s = EG;
            default: s = WG;
        endcase
        return s;
    endfunction

    function automatic state_e yellow_of(input logic [1:0] d);
        state_e s;
        case (d)
            DIR_N:   s = NY;
            DIR_S:   s = SY;
            DIR_E:   s = EY;
            default: s = WY;
        endcase
        return s;
    endfunction

    function automatic logic is_green(input state_e s);
        return (s == NG) || (s == SG) || (s == EG) || (s == WG);
    endfunction

    function automatic logic is_yellow(input state_e s);
        return (s == NY) || (s == SY) || (s == EY) || (s == WY);
    endfunction

    // Priority scan d+1, d+2, d+3, d; no demand at all falls back to d+1.
    function automatic logic [1:0] pick_next(input logic [1:0] d, input logic [3:0] s);
        logic [1:0] c1, c2, c3;
        logic [1:0] r;
        c1 = d + 2'd1;
        c2 = d + 2'd2;
        c3 = d + 2'd3;
        if (s[c1])      r = c1;
        else if (s[c2]) r = c2;
        else if (s[c3]) r = c3;
        else if (s[d])  r = d;
        else            r = c1;
        return r;
    endfunction

`ifdef TRAFFIC_CONTROL_ALL_RED_EN
    // During all-red the state no longer names an approach, so remember it.
    logic [1:0] dir_q;

    always_ff @(posedge clk) begin
        if (rst_a) begin
            dir_q <= DIR_N;
        end else begin
            dir_q <= cur_dir;
        end
    end

    assign cur_dir = (fsm_q.state == AR) ? dir_q : dir_of(fsm_q.state);
`else
    assign cur_dir = dir_of(fsm_q.state);
`endif

    assign sel_dir = pick_next(cur_dir, sens);

    // State register.
    always_ff @(posedge clk) begin
        if (rst_a) begin
            fsm_q.state <= NG;
            fsm_q.cnt   <= '0;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    // Next-state logic.
    always_comb begin
        fsm_d.state = fsm_q.state;
        if (is_green(fsm_q.state)) begin
            if (fsm_q.cnt == GREEN_LAST) begin
                fsm_d.state = yellow_of(cur_dir);
            end
        end else if (is_yellow(fsm_q.state)) begin
            if (fsm_q.cnt == YELLOW_LAST) begin
`ifdef TRAFFIC_CONTROL_ALL_RED_EN
                fsm_d.state = AR;
`else
                fsm_d.state = green_of(sel_dir);
`endif
            end
        end
`ifdef TRAFFIC_CONTROL_ALL_RED_EN
        else if (fsm_q.state == AR) begin
            if (fsm_q.cnt == ALLRED_LAST) begin
                fsm_d.state = green_of(sel_dir);
            end
        end
`endif
        // A re-grant (e.g. EY -> EG) is still a state change and restarts the count.
        fsm_d.cnt = (fsm_d.state != fsm_q.state) ? 8'd0 : fsm_q.cnt + 8'd1;
    end

    // Output decode from registered state only.
    always_comb begin
        n_lights = LAMP_RED;
        s_lights = LAMP_RED;
        e_lights = LAMP_RED;
        w_lights = LAMP_RED;
        case (fsm_q.state)
            NG:      n_lights = LAMP_GREEN;
            NY:      n_lights = LAMP_YELLOW;
            SG:      s_lights = LAMP_GREEN;
            SY:      s_lights = LAMP_YELLOW;
            EG:      e_lights = LAMP_GREEN;
            EY:      e_lights = LAMP_YELLOW;
            WG:      w_lights = LAMP_GREEN;
            WY:      w_lights = LAMP_YELLOW;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_traffic_control.sv
// Randomized bench for traffic_control against a timeline model of the intersection.
// Honours TRAFFIC_CONTROL_ALL_RED_EN to include the all-red clearance in the model.
module tb_traffic_control;

    localparam int G = 8;
    localparam int Y = 3;
`ifdef TRAFFIC_CONTROL_ALL_RED_EN
    localparam int A = 1;
`else
    localparam int A = 0;
`endif
    localparam int PERIOD = G + Y + A;

    logic       clk;
    logic       rst_a;
    logic       x1, x2, x3, x4;
    logic [2:0] n_lights, s_lights, e_lights, w_lights;

    traffic_control #(
        .GREEN_TIME (G),
        .YELLOW_TIME(Y),
        .ALLRED_TIME(1)
    ) dut (
        .clk     (clk),
        .rst_a   (rst_a),
        .x1      (x1),
        .x2      (x2),
        .x3      (x3),
        .x4      (x4),
        .n_lights(n_lights),
        .s_lights(s_lights),
        .e_lights(e_lights),
        .w_lights(w_lights)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;

    // Model: which approach owns the current slot, and cycles since its green began.
    int m_dir = 0;
    int m_t   = 0;

    logic [11:0] exp_q[$];

    task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [11:0] model_lights();
        logic [2:0] lamp;
        logic [11:0] v;
        if (m_t < G)          lamp = 3'b001;
        else if (m_t < G + Y) lamp = 3'b010;
        else                  lamp = 3'b100;
        v = {4{3'b100}};
        case (m_dir)
            0: v[11:9] = lamp;
            1: v[8:6]  = lamp;
            2: v[5:3]  = lamp;
            default: v[2:0] = lamp;
        endcase
        return v;
    endfunction

    // Advance the model across one rising edge with the given inputs.
    task automatic model_step(input logic rst, input logic [3:0] s);
        int nd;
        if (rst) begin
            m_dir = 0;
            m_t   = 0;
        end else if (m_t == PERIOD - 1) begin
            nd = (m_dir + 1) % 4;
            for (int k = 4; k >= 1; k--) begin
                if (s[(m_dir + k) % 4]) nd = (m_dir + k) % 4;
            end
            m_dir = nd;
            m_t   = 0;
        end else begin
            m_t++;
        end
    endtask

    // Driver: called at a falling edge; applies inputs, lets one rising edge pass, checks.
    task automatic drive_cycle(input logic rst, input logic [3:0] s, input string tag);
        logic [11:0] got;
        logic [11:0] exp;
        int nonred;
        logic legal;
        rst_a = rst;
        {x4, x3, x2, x1} = s;
        model_step(rst, s);
        exp_q.push_back(model_lights());
        @(posedge clk);
        @(negedge clk);
        got = {n_lights, s_lights, e_lights, w_lights};
        if (exp_q.size() == 0) begin
            check({tag, "_queue"}, 12'd0, 12'd1);
        end else begin
            exp = exp_q.pop_front();
            check(tag, got, exp);
        end
        nonred = 0;
        legal  = 1'b1;
        for (int h = 0; h < 4; h++) begin
            logic [2:0] l;
            l = got[h*3 +: 3];
            if (l != 3'b100 && l != 3'b010 && l != 3'b001) legal = 1'b0;
            if (l != 3'b100) nonred++;
        end
        if (nonred > 1) legal = 1'b0;
        check({tag, "_legal"}, {11'd0, legal}, 12'd1);
    endtask

    initial begin
        int guard;
        logic found;
        rst_a = 1'b1;
        {x4, x3, x2, x1} = 4'b0000;
        @(negedge clk);

        // Reset held for two edges with arbitrary sensors.
        drive_cycle(1'b1, 4'($urandom_range(0, 15)), "reset");
        drive_cycle(1'b1, 4'($urandom_range(0, 15)), "reset");

        for (int i = 0; i < 3 * 4 * PERIOD; i++) drive_cycle(1'b0, 4'b1111, "all_ones");

        drive_cycle(1'b1, 4'b0000, "reset2");
        for (int i = 0; i < 4 * PERIOD; i++) drive_cycle(1'b0, 4'b0100, "east_only");

        drive_cycle(1'b1, 4'b0000, "reset3");
        for (int i = 0; i < 5 * PERIOD; i++) drive_cycle(1'b0, 4'b0000, "no_demand");

        // Run to East yellow, then reset in the middle of it.
        drive_cycle(1'b1, 4'b0000, "reset4");
        found = 1'b0;
        guard = 0;
        while (!found && guard < 200) begin
            drive_cycle(1'b0, 4'b1111, "to_ey");
            if (m_dir == 2 && m_t == G + 1) found = 1'b1;
            guard++;
        end
        check("reach_ey", {11'd0, found}, 12'd1);
        drive_cycle(1'b1, 4'b1111, "mid_reset");
        for (int i = 0; i < 2 * PERIOD; i++) drive_cycle(1'b0, 4'b1111, "after_reset");

        // Random sensors every cycle, with rare resets.
        for (int i = 0; i < 3000; i++) begin
            drive_cycle(($urandom_range(0, 199) == 0), 4'($urandom_range(0, 15)), "random");
        end

        // Sparse demand: mostly zero sensors, occasional single-cycle pulses.
        for (int i = 0; i < 1000; i++) begin
            logic [3:0] s;
            s = ($urandom_range(0, 3) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0000;
            drive_cycle(1'b0, s, "sparse");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/traffic_control.md
# traffic_control

Four-way intersection signal controller driving North, South, East and West signal heads from vehicle-presence sensors. Green is granted to one approach at a time in round-robin order N→S→E→W, skipping approaches with no waiting vehicle. Each green is followed by yellow. It sits between the sensor front-end and the lamp drivers as a single-clock Moore FSM.

## Interface

**Parameters**
- `GREEN_TIME`, default 8: green phase length in clock cycles. Legal range 1..255.
- `YELLOW_TIME`, default 3: yellow phase length in cycles. Legal range 1..255.
- `ALLRED_TIME`, default 1: all-red clearance length in cycles. Used only when the `TRAFFIC_CONTROL_ALL_RED_EN` macro is defined. Legal range 1..255.

**Ports**
- `clk` input, 1 bit: single clock; all logic is on its rising edge.
- `rst_a` input, 1 bit: reset, synchronous and active-high.
- `x1` input, 1 bit: North vehicle sensor; 1 means a vehicle is waiting.
- `x2` input, 1 bit: South vehicle sensor.
- `x3` input, 1 bit: East vehicle sensor.
- `x4` input, 1 bit: West vehicle sensor.
- `n_lights` output, 3 bits: North lamps as {red, yellow, green}.
- `s_lights` output, 3 bits: South lamps, same encoding.
- `e_lights` output, 3 bits: East lamps, same encoding.
- `w_lights` output, 3 bits: West lamps, same encoding.

## Operation

- **Lamp encoding:**
  - RED = 3'b100, YELLOW = 3'b010, GREEN = 3'b001.
  - Exactly one bit is set per output at all times.
  - At most one approach is non-red at any time.
- **FSM states:** NG, NY, SG, SY, EG, EY, WG, WY.
  - Add AR (all-red) when `TRAFFIC_CONTROL_ALL_RED_EN` is defined.
  - In state xG the active approach shows GREEN and the others show RED.
  - In state xY the active approach shows YELLOW and the others show RED.
- **Phase counter:** 8-bit, cleared on every state change, incremented otherwise.
  - Green ends when the counter equals GREEN_TIME-1; yellow ends when it equals YELLOW_TIME-1.
  - Green length is fixed; sensors never shorten or extend it.
- **Next-approach selection:** made at the last cycle of yellow.
  - Scan from the current approach d in order d+1, d+2, d+3, d (N→S→E→W→N).
  - The first approach whose sensor is 1 wins.
  - If all sensors are 0, the next approach is d+1 (plain rotation).
  - If only the current approach's sensor is 1, the current approach is re-granted after its yellow.
- **Sensors:**
  - Sampled only at the selection edge; their values at other cycles are ignored.
  - Sensors are level-sensitive and not latched; a pulse that misses the selection edge is lost.
- **Reset:**
  - While `rst_a` is 1 at a rising edge: state = NG, counter = 0.
  - Reset outputs: `n_lights`=3'b001, `s_lights`=`e_lights`=`w_lights`=3'b100.
  - Reset asserted mid-phase forces NG on the next edge, regardless of state.

## Timing

- Outputs are registered, or decoded purely from registered state; there is no combinational path from `x1`..`x4` to any output.
- Counting starts at the first rising edge with `rst_a`=0; that edge is cycle 0 of NG.
  - North is green for GREEN_TIME cycles.
  - North is then yellow for YELLOW_TIME cycles.
  - The selected approach turns green on the following edge.
- Full cycle with all sensors 1: 4×(GREEN_TIME+YELLOW_TIME) cycles, which is 44 at defaults.
- Sensors must meet setup/hold around the rising edge; the bench changes them away from edges.

## Configuration

- **`TRAFFIC_CONTROL_ALL_RED_EN` defined:**
  - After every yellow, the FSM enters AR for ALLRED_TIME cycles with all four outputs = 3'b100.
  - Selection is made at the last cycle of AR, not of yellow.
  - Full cycle = 4×(GREEN_TIME+YELLOW_TIME+ALLRED_TIME) cycles.
- **Not defined:**
  - AR state and its logic are absent.
  - Yellow goes directly to the next green.

## Test plan

- **Reset:** hold `rst_a`=1 for 2 edges, sensors any → N=001, S=E=W=100; release → N stays green exactly 8 cycles, then 010 for 3 cycles.
- **All sensors 1:** `{x1,x2,x3,x4}`=4'b1111 → green order N,S,E,W,N…; each green 8 cycles, each yellow 3 cycles; period 44 cycles; never two non-red heads.
- **Sensor skip:** `x3`=1, others 0 → after N yellow, E turns green; after E yellow, E is green again; S and W stay 100 throughout.
- **No demand:** all sensors 0 → plain rotation N→S→E→W.
- **Mid-phase reset:** assert `rst_a` during EY → next edge N=001, others 100, counter restarts at 0.
- **All-red macro:** with `TRAFFIC_CONTROL_ALL_RED_EN` defined and all sensors 1 → 1 cycle of all 100 between each yellow and the next green; period 48 cycles.
